// File: rtl/approx_mult_pipe_wxw.sv
// rtl/approx_mult_pipe_wxw.sv - three-stage valid/ready WxW multiplier with exact/approximate mode
// Approximate mode drops product columns below L and adds an OR-compensation bit at column L.
module approx_mult_pipe_wxw #(
  parameter int W     = 8,
  parameter int L     = 6,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       x,
  input  logic [W-1:0]       y,
  input  logic               mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*W-1:0]     z,
  output logic               z_mode,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   approx_cnt
);

  localparam int              PW        = 2 * W;
  localparam int              H         = W / 2;
  localparam int              COMP_COL  = (L > 0) ? L - 1 : 0;
  localparam logic [PW-1:0]   ALL_COLS  = {PW{1'b1}};
  localparam logic [PW-1:0]   KEEP_COLS = ALL_COLS << L;
  localparam logic [PW-1:0]   COMP_VAL  = {{(PW-1){1'b0}}, 1'b1} << L;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic               s1_valid, s2_valid, s3_valid;
  logic               s1_adv, s2_adv, s3_adv;
  logic [W-1:0]       s1_x, s1_y;
  logic               s1_mode, s2_mode;
  logic [PW-1:0]      s2_lo, s2_hi;
  logic               s2_comp;
  logic [PW-1:0]      s3_z;
  logic               s3_mode;

  logic [PW-1:0]      row, col_mask, sum_lo, sum_hi;
  logic               col_or, comp;
  logic               accept;

  // Each stage may load when its successor is empty or moving; this collapses bubbles.
  assign s3_adv   = !s3_valid || out_ready;
  assign s2_adv   = !s2_valid || s3_adv;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;
  assign accept   = in_valid && in_ready;

  assign out_valid = s3_valid;
  assign z         = s3_z;
  assign z_mode    = s3_mode;

  // A single shifted row has no carries, so masking it by column equals dropping those pp terms.
  always_comb begin
    row      = '0;
    sum_lo   = '0;
    sum_hi   = '0;
    col_or   = 1'b0;
    col_mask = s1_mode ? KEEP_COLS : ALL_COLS;
    for (int i = 0; i < W; i++) begin
      row = s1_x[i] ? ({{W{1'b0}}, s1_y} << i) : '0;
      if (i < H) begin
        sum_lo = sum_lo + (row & col_mask);
      end else begin
        sum_hi = sum_hi + (row & col_mask);
      end
      col_or = col_or | row[COMP_COL];
    end
    comp = s1_mode && (L > 0) && col_or;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_mode  <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_x    <= x;
        s1_y    <= y;
        s1_mode <= mode;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_lo    <= '0;
      s2_hi    <= '0;
      s2_comp  <= 1'b0;
      s2_mode  <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_lo   <= sum_lo;
        s2_hi   <= sum_hi;
        s2_comp <= comp;
        s2_mode <= s1_mode;
      end
    end
  end

  // Output data only changes when a real beat moves in, so z is stable under stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_valid <= 1'b0;
      s3_z     <= '0;
      s3_mode  <= 1'b0;
    end else if (s3_adv) begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        s3_z    <= s2_lo + s2_hi + (s2_comp ? COMP_VAL : '0);
        s3_mode <= s2_mode;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      approx_cnt <= '0;
    end else if (cnt_clr) begin
      approx_cnt <= '0;
    end else if (accept && mode && approx_cnt != CNT_MAX) begin
      approx_cnt <= approx_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_approx_mult_pipe_wxw.sv
// tb/tb_approx_mult_pipe_wxw.sv - directed-vector bench for approx_mult_pipe_wxw
// DUT a: W=8 L=6 CNT_W=4; DUT b: W=8 L=0 CNT_W=16.
module tb_approx_mult_pipe_wxw;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        a_in_valid, a_in_ready, a_mode, a_out_valid, a_out_ready, a_z_mode, a_cnt_clr;
  logic [7:0]  a_x, a_y;
  logic [15:0] a_z;
  logic [3:0]  a_cnt;
  logic        b_in_valid, b_in_ready, b_mode, b_out_valid, b_out_ready, b_z_mode, b_cnt_clr;
  logic [7:0]  b_x, b_y;
  logic [15:0] b_z;
  logic [15:0] b_cnt;

  int n_vec = 0;
  int n_err = 0;

  approx_mult_pipe_wxw #(.W(8), .L(6), .CNT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .x(a_x), .y(a_y), .mode(a_mode), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .z(a_z), .z_mode(a_z_mode), .cnt_clr(a_cnt_clr), .approx_cnt(a_cnt)
  );

  approx_mult_pipe_wxw #(.W(8), .L(0), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .x(b_x), .y(b_y), .mode(b_mode), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .z(b_z), .z_mode(b_z_mode), .cnt_clr(b_cnt_clr), .approx_cnt(b_cnt)
  );

  // Column-by-column reference: keep pp(i,j) with i+j>=l, OR-compensate column l-1.
  function automatic logic [15:0] model(input logic [7:0] xv, input logic [7:0] yv,
                                        input logic m, input int l);
    logic [15:0] acc;
    logic        c;
    acc = '0;
    c   = 1'b0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        if (xv[i] && yv[j]) begin
          if (!m || (i + j) >= l) acc = acc + (16'd1 << (i + j));
          if (m && l > 0 && (i + j) == l - 1) c = 1'b1;
        end
    if (c) acc = acc + (16'd1 << l);
    return acc;
  endfunction

  task automatic a_idle();
    a_in_valid = 1'b0; a_x = '0; a_y = '0; a_mode = 1'b0; a_cnt_clr = 1'b0;
  endtask

  task automatic b_idle();
    b_in_valid = 1'b0; b_x = '0; b_y = '0; b_mode = 1'b0; b_cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    n_vec++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", a_out_valid); end
    n_vec++; if (a_z !== 16'd0) begin n_err++; $display("FAIL reset_z: got %h expected 0000", a_z); end
    n_vec++; if (a_z_mode !== 1'b0) begin n_err++; $display("FAIL reset_z_mode: got %b expected 0", a_z_mode); end
    n_vec++; if (a_cnt !== 4'd0) begin n_err++; $display("FAIL reset_cnt: got %0d expected 0", a_cnt); end
    n_vec++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", a_in_ready); end
    n_vec++; if (b_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_b_out_valid: got %b expected 0", b_out_valid); end
  endtask

  task automatic test_single_beats();
    logic [7:0]  tx [7];
    logic [7:0]  ty [7];
    logic        tm [7];
    logic [15:0] tz [7];
    int lat;
    tx = '{8'd255, 8'd255, 8'd32, 8'd32, 8'd3, 8'd3, 8'd32};
    ty = '{8'd255, 8'd255, 8'd1,  8'd2,  8'd3, 8'd3, 8'd1};
    tm = '{1'b0,   1'b1,   1'b1,  1'b1,  1'b1, 1'b0, 1'b0};
    tz = '{16'hFE01, 16'hFD00, 16'd64, 16'd64, 16'd0, 16'd9, 16'd32};
    a_out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      a_in_valid = 1'b1; a_x = tx[k]; a_y = ty[k]; a_mode = tm[k];
      @(posedge clk); #1;
      a_in_valid = 1'b0;
      lat = 1;
      while (!a_out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
      n_vec++; if (lat !== 3) begin n_err++; $display("FAIL single_latency[%0d]: got %0d expected 3", k, lat); end
      n_vec++; if (a_z !== tz[k]) begin n_err++; $display("FAIL single_z[%0d]: got %h expected %h", k, a_z, tz[k]); end
      n_vec++; if (a_z_mode !== tm[k]) begin n_err++; $display("FAIL single_z_mode[%0d]: got %b expected %b", k, a_z_mode, tm[k]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_z[$];
    logic        exp_m[$];
    logic [15:0] ez;
    logic        em, held, held_m, acc;
    logic [15:0] held_z;
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0; held = 1'b0; held_z = '0; held_m = 1'b0;
    a_idle();
    while ((sent < 20 || got < 20) && cyc < 600) begin
      a_out_ready = 1'($urandom_range(0, 1));
      if (!a_in_valid && sent < 20 && $urandom_range(0, 3) != 0) begin
        a_in_valid = 1'b1; a_x = 8'($urandom); a_y = 8'($urandom); a_mode = 1'($urandom);
      end
      #1;
      if (held) begin
        n_vec++;
        if (a_out_valid !== 1'b1 || a_z !== held_z || a_z_mode !== held_m) begin
          n_err++; $display("FAIL b2b_stall_stable: got v=%b z=%h m=%b expected v=1 z=%h m=%b",
                            a_out_valid, a_z, a_z_mode, held_z, held_m);
        end
      end
      if (a_out_valid && a_out_ready) begin
        n_vec++;
        if (exp_z.size() == 0) begin
          n_err++; $display("FAIL b2b_extra_beat: got z=%h expected no beat", a_z);
        end else begin
          ez = exp_z.pop_front(); em = exp_m.pop_front();
          if (a_z !== ez || a_z_mode !== em) begin
            n_err++; $display("FAIL b2b_result[%0d]: got z=%h m=%b expected z=%h m=%b", got, a_z, a_z_mode, ez, em);
          end
        end
        got++;
      end
      held = a_out_valid && !a_out_ready; held_z = a_z; held_m = a_z_mode;
      acc = a_in_valid && a_in_ready;
      if (acc) begin exp_z.push_back(model(a_x, a_y, a_mode, 6)); exp_m.push_back(a_mode); end
      @(posedge clk); #1;
      if (acc) begin a_in_valid = 1'b0; sent++; end
      cyc++;
    end
    n_vec++;
    if (sent != 20 || got != 20) begin
      n_err++; $display("FAIL b2b_count: got sent=%0d recv=%0d expected 20/20", sent, got);
    end
    a_idle(); a_out_ready = 1'b1;
    repeat (5) @(posedge clk); #1;
  endtask

  task automatic test_full_stall();
    a_idle(); a_out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a_in_valid = 1'b1; a_x = 8'(10 + k); a_y = 8'd3; a_mode = 1'b0;
      #1;
      n_vec++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL stall_fill_ready[%0d]: got %b expected 1", k, a_in_ready); end
      @(posedge clk); #1;
    end
    a_x = 8'd13;
    #1;
    n_vec++; if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL stall_full_ready: got %b expected 0", a_in_ready); end
    @(posedge clk); #1;
    n_vec++; if (a_out_valid !== 1'b1 || a_z !== 16'd30) begin n_err++; $display("FAIL stall_hold: got v=%b z=%0d expected v=1 z=30", a_out_valid, a_z); end
    a_out_ready = 1'b1;
    #1;
    n_vec++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL stall_release_ready: got %b expected 1", a_in_ready); end
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (a_out_valid !== 1'b1 || a_z !== 16'((10 + k) * 3)) begin
        n_err++; $display("FAIL stall_drain[%0d]: got v=%b z=%0d expected v=1 z=%0d", k, a_out_valid, a_z, (10 + k) * 3);
      end
      @(posedge clk); #1;
      if (k == 0) a_in_valid = 1'b0;
    end
    n_vec++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL stall_empty: got %b expected 0", a_out_valid); end
  endtask

  task automatic test_counter();
    a_idle(); a_out_ready = 1'b1;
    a_cnt_clr = 1'b1;
    @(posedge clk); #1;
    a_cnt_clr = 1'b0;
    n_vec++; if (a_cnt !== 4'd0) begin n_err++; $display("FAIL cnt_clear: got %0d expected 0", a_cnt); end
    for (int k = 0; k < 17; k++) begin
      a_in_valid = 1'b1; a_x = 8'(k); a_y = 8'd1; a_mode = 1'b1;
      @(posedge clk); #1;
      if (k == 9) begin
        n_vec++; if (a_cnt !== 4'd10) begin n_err++; $display("FAIL cnt_ten: got %0d expected 10", a_cnt); end
      end
    end
    a_in_valid = 1'b0;
    n_vec++; if (a_cnt !== 4'd15) begin n_err++; $display("FAIL cnt_saturate: got %0d expected 15", a_cnt); end
    a_in_valid = 1'b1; a_mode = 1'b1; a_cnt_clr = 1'b1;
    @(posedge clk); #1;
    a_cnt_clr = 1'b0;
    n_vec++; if (a_cnt !== 4'd0) begin n_err++; $display("FAIL cnt_clear_wins: got %0d expected 0", a_cnt); end
    @(posedge clk); #1;
    a_mode = 1'b0;
    n_vec++; if (a_cnt !== 4'd1) begin n_err++; $display("FAIL cnt_after_clear: got %0d expected 1", a_cnt); end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    n_vec++; if (a_cnt !== 4'd1) begin n_err++; $display("FAIL cnt_exact_ignored: got %0d expected 1", a_cnt); end
    repeat (5) @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat;
    a_idle(); a_out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      a_in_valid = 1'b1; a_x = 8'd255; a_y = 8'd255; a_mode = 1'b1;
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_out_valid: got %b expected 0", a_out_valid); end
    n_vec++; if (a_cnt !== 4'd0) begin n_err++; $display("FAIL mid_rst_cnt: got %0d expected 0", a_cnt); end
    n_vec++; if (a_z !== 16'd0 || a_z_mode !== 1'b0) begin n_err++; $display("FAIL mid_rst_z: got z=%h m=%b expected 0000/0", a_z, a_z_mode); end
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      n_vec++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_stale[%0d]: got %b expected 0", k, a_out_valid); end
      @(posedge clk); #1;
    end
    a_in_valid = 1'b1; a_x = 8'd32; a_y = 8'd1; a_mode = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    lat = 1;
    while (!a_out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    n_vec++; if (lat !== 3 || a_z !== 16'd64) begin n_err++; $display("FAIL mid_rst_fresh: got lat=%0d z=%0d expected lat=3 z=64", lat, a_z); end
    n_vec++; if (a_cnt !== 4'd1) begin n_err++; $display("FAIL mid_rst_fresh_cnt: got %0d expected 1", a_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_l0();
    logic [7:0]  tx [3];
    logic [7:0]  ty [3];
    logic [15:0] tz [3];
    int lat;
    tx = '{8'd255, 8'd3, 8'd32};
    ty = '{8'd255, 8'd3, 8'd1};
    tz = '{16'hFE01, 16'd9, 16'd32};
    b_idle(); b_out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      b_in_valid = 1'b1; b_x = 8'd200; b_y = 8'd7; b_mode = 1'b1;
      @(posedge clk); #1;
    end
    b_in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (b_out_valid !== 1'b0 || b_cnt !== 16'd0) begin n_err++; $display("FAIL l0_rst: got v=%b cnt=%0d expected 0/0", b_out_valid, b_cnt); end
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      b_in_valid = 1'b1; b_x = tx[k]; b_y = ty[k]; b_mode = 1'b1;
      @(posedge clk); #1;
      b_in_valid = 1'b0;
      lat = 1;
      while (!b_out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
      n_vec++;
      if (lat !== 3 || b_z !== tz[k] || b_z_mode !== 1'b1) begin
        n_err++; $display("FAIL l0_exact[%0d]: got lat=%0d z=%h m=%b expected lat=3 z=%h m=1", k, lat, b_z, b_z_mode, tz[k]);
      end
    end
    n_vec++; if (b_cnt !== 16'd3) begin n_err++; $display("FAIL l0_cnt: got %0d expected 3", b_cnt); end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    a_idle(); b_idle();
    a_out_ready = 1'b0; b_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_single_beats();
    test_back_to_back();
    test_full_stall();
    test_counter();
    test_reset_mid();
    test_l0();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
